secuenciador_melodia: RTL and testbench

Melody sequencer and key-mode controller for the tone divider. It owns the divider's 32-bit `freq` input. In idle it converts the seven note keys into a frequency. On `start` it plays a fixed 14-note melody from internal ROM, with programmable note-unit and inter-note gap lengths. It sits between the key inputs and `divisor_frecuencia`, replacing the free-running key decoder in the top level.

---
 rtl/secuenciador_melodia.sv | 249 ++++++++++++++++++++++++
 tb/tb_secuenciador_melodia.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_melodia.sv
// secuenciador_melodia: key-mode frequency selection plus a 14-note ROM melody
// player with programmable note-unit and inter-note gap lengths. Owns the
// 32-bit frequency word consumed by the tone divider.
module secuenciador_melodia #(
    parameter int unsigned UNIT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  teclas,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic [31:0] freq,
    output logic        playing,
    output logic [3:0]  idx,
    output logic        done
);

    localparam int unsigned CNT_W    = 24;
    localparam int unsigned NOTE_W   = 3;
    localparam int unsigned DUR_W    = 2;
    localparam int unsigned ENTRY_W  = NOTE_W + DUR_W;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned FREQ_W   = 32;
    localparam int unsigned KEYS     = 7;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(13);
    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam bit               HAS_GAP   = (GAP_CYCLES != 0);

    // Note codes: 0 is silence, 1..7 are DO..SI of the first octave.
    localparam logic [NOTE_W-1:0] NOTE_SIL = NOTE_W'(0);
    localparam logic [NOTE_W-1:0] NOTE_DO  = NOTE_W'(1);
    localparam logic [NOTE_W-1:0] NOTE_RE  = NOTE_W'(2);
    localparam logic [NOTE_W-1:0] NOTE_MI  = NOTE_W'(3);
    localparam logic [NOTE_W-1:0] NOTE_FA  = NOTE_W'(4);
    localparam logic [NOTE_W-1:0] NOTE_SOL = NOTE_W'(5);
    localparam logic [NOTE_W-1:0] NOTE_LA  = NOTE_W'(6);
    localparam logic [NOTE_W-1:0] NOTE_SI  = NOTE_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Note code to frequency word in Hz.
    function automatic logic [FREQ_W-1:0] note_hz(input logic [NOTE_W-1:0] note);
        logic [FREQ_W-1:0] hz;
        case (note)
            NOTE_DO:  hz = FREQ_W'(1046);
            NOTE_RE:  hz = FREQ_W'(1174);
            NOTE_MI:  hz = FREQ_W'(1318);
            NOTE_FA:  hz = FREQ_W'(1396);
            NOTE_SOL: hz = FREQ_W'(1567);
            NOTE_LA:  hz = FREQ_W'(1760);
            NOTE_SI:  hz = FREQ_W'(1975);
            default:  hz = '0;
        endcase
        return hz;
    endfunction

    // Lowest pressed key wins; no key gives silence.
    function automatic logic [NOTE_W-1:0] key_note(input logic [KEYS-1:0] keys);
        logic [NOTE_W-1:0] note;
        note = NOTE_SIL;
        for (int b = KEYS - 1; b >= 0; b--) begin
            if (keys[b]) begin
                note = NOTE_W'(b + 1);
            end
        end
        return note;
    endfunction

    // Melody ROM: {note, duration in units}.
    function automatic logic [ENTRY_W-1:0] rom_entry(input logic [IDX_W-1:0] i);
        logic [ENTRY_W-1:0] e;
        case (i)
            4'd0:    e = {NOTE_DO,  2'd1};
            4'd1:    e = {NOTE_DO,  2'd1};
            4'd2:    e = {NOTE_SOL, 2'd1};
            4'd3:    e = {NOTE_SOL, 2'd1};
            4'd4:    e = {NOTE_LA,  2'd1};
            4'd5:    e = {NOTE_LA,  2'd1};
            4'd6:    e = {NOTE_SOL, 2'd2};
            4'd7:    e = {NOTE_FA,  2'd1};
            4'd8:    e = {NOTE_FA,  2'd1};
            4'd9:    e = {NOTE_MI,  2'd1};
            4'd10:   e = {NOTE_MI,  2'd1};
            4'd11:   e = {NOTE_RE,  2'd1};
            4'd12:   e = {NOTE_RE,  2'd1};
            4'd13:   e = {NOTE_DO,  2'd2};
            default: e = {NOTE_SIL, 2'd1};
        endcase
        return e;
    endfunction

    state_e             state_q, state_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               playing_q, playing_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   unit_cnt_q, unit_cnt_d;
    logic [DUR_W-1:0]   units_q, units_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [FREQ_W-1:0]  key_hz;
    logic [IDX_W-1:0]   idx_next;
    logic [ENTRY_W-1:0] cur_entry;
    logic [ENTRY_W-1:0] next_entry;
    logic [ENTRY_W-1:0] first_entry;
    logic [DUR_W-1:0]   cur_dur;
    logic [DUR_W-1:0]   units_inc;
    logic               entry_end;

    // ROM lookups and key decoding used by the next-state logic.
    assign key_hz      = note_hz(key_note(teclas));
    assign idx_next    = IDX_W'(idx_q + IDX_W'(1));
    assign cur_entry   = rom_entry(idx_q);
    assign next_entry  = rom_entry(idx_next);
    assign first_entry = rom_entry(IDX_W'(0));
    assign cur_dur     = cur_entry[DUR_W-1:0];
    assign units_inc   = DUR_W'(units_q + DUR_W'(1));

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            freq_q     <= '0;
            playing_q  <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            unit_cnt_q <= '0;
            units_q    <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            freq_q     <= freq_d;
            playing_q  <= playing_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            unit_cnt_q <= unit_cnt_d;
            units_q    <= units_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Next-state logic: key mode, note timing, gap timing, melody sequencing, abort.
    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        unit_cnt_d = unit_cnt_q;
        units_d    = units_q;
        gap_cnt_d  = gap_cnt_q;
        entry_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                freq_d = key_hz;
                if (start && !stop) begin
                    state_d    = ST_PLAY;
                    idx_d      = '0;
                    freq_d     = note_hz(first_entry[ENTRY_W-1:DUR_W]);
                    unit_cnt_d = '0;
                    units_d    = '0;
                    gap_cnt_d  = '0;
                end
            end

            ST_PLAY: begin
                if (unit_cnt_q == UNIT_LAST) begin
                    unit_cnt_d = '0;
                    units_d    = units_inc;
                    if (units_inc == cur_dur) begin
                        if (HAS_GAP) begin
                            state_d    = ST_GAP;
                            freq_d     = '0;
                            unit_cnt_d = '0;
                            units_d    = '0;
                            gap_cnt_d  = '0;
                        end else begin
                            entry_end = 1'b1;
                        end
                    end
                end else begin
                    unit_cnt_d = CNT_W'(unit_cnt_q + CNT_W'(1));
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    entry_end = 1'b1;
                end else begin
                    gap_cnt_d = CNT_W'(gap_cnt_q + CNT_W'(1));
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                freq_d  = '0;
            end
        endcase

        // End of an entry's note+gap: next note, wrap around, or finish.
        if (entry_end) begin
            unit_cnt_d = '0;
            units_d    = '0;
            gap_cnt_d  = '0;
            if (idx_q != LAST_IDX) begin
                state_d = ST_PLAY;
                idx_d   = idx_next;
                freq_d  = note_hz(next_entry[ENTRY_W-1:DUR_W]);
            end else if (loop) begin
                state_d = ST_PLAY;
                idx_d   = '0;
                freq_d  = note_hz(first_entry[ENTRY_W-1:DUR_W]);
            end else begin
                state_d = ST_IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
                freq_d  = key_hz;
            end
        end

        // Abort overrides everything while a melody is running.
        if ((state_q != ST_IDLE) && stop) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            done_d     = 1'b0;
            freq_d     = key_hz;
            unit_cnt_d = '0;
            units_d    = '0;
            gap_cnt_d  = '0;
        end

        playing_d = (state_d != ST_IDLE);
    end

    assign freq    = freq_q;
    assign playing = playing_q;
    assign idx     = idx_q;
    assign done    = done_q;

endmodule

// File: tb/tb_secuenciador_melodia.sv
// Self-checking bench for secuenciador_melodia: expected per-edge outputs are
// queued when stimulus is applied and compared as the DUT produces them.
module tb_secuenciador_melodia;

    localparam int unsigned UNIT = 4;
    localparam int unsigned GAP  = 1;

    logic        clk;
    logic        reset;
    logic [6:0]  teclas;
    logic        start;
    logic        stop;
    logic        loop;
    logic [31:0] freq;
    logic        playing;
    logic [3:0]  idx;
    logic        done;

    typedef struct packed {
        logic [31:0] freq;
        logic        playing;
        logic [3:0]  idx;
        logic        done;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference melody in Hz and duration units.
    int mel_hz  [14] = '{1046, 1046, 1567, 1567, 1760, 1760, 1567,
                         1396, 1396, 1318, 1318, 1174, 1174, 1046};
    int mel_dur [14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};

    secuenciador_melodia #(
        .UNIT_CYCLES(UNIT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .teclas (teclas),
        .start  (start),
        .stop   (stop),
        .loop   (loop),
        .freq   (freq),
        .playing(playing),
        .idx    (idx),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic [31:0] f, input logic p, input logic [3:0] i,
                                input logic d);
        obs_t o;
        o.freq    = f;
        o.playing = p;
        o.idx     = i;
        o.done    = d;
        return o;
    endfunction

    task automatic compare_front(input string tag);
        obs_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, " queue_size"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, " freq"},    freq,          e.freq);
        check_eq({tag, " playing"}, 32'(playing),  32'(e.playing));
        check_eq({tag, " idx"},     32'(idx),      32'(e.idx));
        check_eq({tag, " done"},    32'(done),     32'(e.done));
    endtask

    task automatic step_check(input string tag);
        @(posedge clk);
        #1;
        compare_front(tag);
    endtask

    // Queue the first n per-edge expectations of a playback started at E0.
    task automatic push_play(input int n, input bit loop_on, input logic [31:0] key_hz);
        int pushed;
        int note_len;
        pushed = 0;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0 || loop_on) begin
                for (int i = 0; i < 14; i++) begin
                    note_len = mel_dur[i] * int'(UNIT);
                    for (int c = 0; c < note_len + int'(GAP); c++) begin
                        if (pushed < n) begin
                            exp_q.push_back(mk((c < note_len) ? 32'(mel_hz[i]) : 32'd0,
                                               1'b1, 4'(i), 1'b0));
                            pushed++;
                        end
                    end
                end
            end
        end
        if (!loop_on && pushed < n) begin
            exp_q.push_back(mk(key_hz, 1'b0, 4'd0, 1'b1));
            pushed++;
        end
        while (pushed < n) begin
            exp_q.push_back(mk(key_hz, 1'b0, 4'd0, 1'b0));
            pushed++;
        end
    endtask

    // Drive start at E0 (and optionally again at restart_at) and check n edges.
    task automatic run_play(input string tag, input int n, input int restart_at);
        for (int k = 0; k < n; k++) begin
            start = (k == 0) || (k == restart_at);
            step_check($sformatf("%s E%0d", tag, k));
            start = 1'b0;
        end
    endtask

    initial begin
        reset  = 1'b0;
        teclas = 7'b0000100;
        start  = 1'b0;
        stop   = 1'b0;
        loop   = 1'b0;

        #2;
        exp_q.push_back(mk(32'd0, 1'b0, 4'd0, 1'b0));
        compare_front("reset");

        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(mk(32'd1318, 1'b0, 4'd0, 1'b0));
        step_check("key_mi");
        teclas = 7'b1000101;
        exp_q.push_back(mk(32'd1046, 1'b0, 4'd0, 1'b0));
        step_check("key_prio");
        teclas = 7'b0000000;
        exp_q.push_back(mk(32'd0, 1'b0, 4'd0, 1'b0));
        step_check("key_none");
        teclas = 7'b0001000;
        exp_q.push_back(mk(32'd1396, 1'b0, 4'd0, 1'b0));
        step_check("key_fa");

        // Full melody; keys held during playback must not leak into freq.
        push_play(80, 1'b0, 32'd1396);
        run_play("melody", 80, -1);

        // Restart pulse mid-playback is ignored.
        push_play(80, 1'b0, 32'd1396);
        run_play("restart", 80, 20);

        // start and stop together in idle: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        exp_q.push_back(mk(32'd1396, 1'b0, 4'd0, 1'b0));
        exp_q.push_back(mk(32'd1396, 1'b0, 4'd0, 1'b0));
        step_check("collision0");
        step_check("collision1");
        start = 1'b0;
        stop  = 1'b0;

        // Looping: melody wraps to entry 0 without done.
        loop = 1'b1;
        push_play(84, 1'b1, 32'd0);
        run_play("loop", 84, -1);
        loop   = 1'b0;
        stop   = 1'b1;
        teclas = 7'b0100000;
        exp_q.push_back(mk(32'd1760, 1'b0, 4'd0, 1'b0));
        step_check("stop_loop");
        stop = 1'b0;

        // Stop sampled at E2 in the middle of the first note.
        push_play(2, 1'b0, 32'd0);
        run_play("stopnote", 2, -1);
        stop = 1'b1;
        exp_q.push_back(mk(32'd1760, 1'b0, 4'd0, 1'b0));
        step_check("stopnote E2");
        stop = 1'b0;
        exp_q.push_back(mk(32'd1760, 1'b0, 4'd0, 1'b0));
        step_check("stopnote E3");

        // Asynchronous reset during the first gap.
        teclas = 7'b0000000;
        push_play(5, 1'b0, 32'd0);
        run_play("gap", 5, -1);
        #1;
        reset = 1'b0;
        #1;
        exp_q.push_back(mk(32'd0, 1'b0, 4'd0, 1'b0));
        compare_front("async_reset");
        teclas = 7'b0000010;
        exp_q.push_back(mk(32'd0, 1'b0, 4'd0, 1'b0));
        step_check("reset_held");
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(mk(32'd1174, 1'b0, 4'd0, 1'b0));
        step_check("key_re");

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
